// File: rtl/fp_pkg.sv
// Shared types and sizing for the FP register-file writeback path.
package fp_pkg;

  localparam int unsigned FLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = $clog2(NREG);

  typedef logic [REG_AW-1:0] freg_idx_t;

  typedef struct packed {
    freg_idx_t       frd;
    logic [FLEN-1:0] data;
  } fp_wb_t;

endpackage

// File: rtl/fp_writeback_ctrl_fifo.sv
// Small result buffer between the FPU and the register-file write port.
module fp_wb_fifo
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  fp_wb_t data_i,
  input  logic   pop_i,
  output fp_wb_t data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fp_wb_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_writeback_ctrl.sv
// FP register-file write controller: load/FPU writeback merge plus pending-write
// scoreboard that stalls issue on RAW/WAW hazards.
module fp_writeback_ctrl
  import fp_pkg::*;
#(
  parameter  int unsigned FLEN       = fp_pkg::FLEN,
  parameter  int unsigned NREG       = fp_pkg::NREG,
  parameter  int unsigned FIFO_DEPTH = 2,
  localparam int unsigned REG_AW     = $clog2(NREG)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   issue_valid_i,
  input  logic [REG_AW-1:0]      issue_frd_i,
  input  logic                   issue_wr_i,
  input  logic [2:0][REG_AW-1:0] issue_rs_i,
  input  logic [2:0]             issue_rs_use_i,
  output logic                   issue_stall_o,
  input  logic                   fpu_valid_i,
  output logic                   fpu_ready_o,
  input  logic [REG_AW-1:0]      fpu_frd_i,
  input  logic [FLEN-1:0]        fpu_data_i,
  input  logic                   ld_valid_i,
  input  logic [REG_AW-1:0]      ld_frd_i,
  input  logic [FLEN-1:0]        ld_data_i,
  output logic                   fregwrite_o,
  output logic [REG_AW-1:0]      frd_o,
  output logic [FLEN-1:0]        writeback_data_o,
  output logic                   idle_o
);

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_d;
  logic            raw;
  logic            waw;
  logic            issue_accept;

  fp_wb_t          fifo_in;
  fp_wb_t          fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;

  always_comb begin
    raw = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      raw = raw | (issue_rs_use_i[k] & pend[issue_rs_i[k]]);
    end
  end

  assign waw           = issue_wr_i & pend[issue_frd_i];
  assign issue_stall_o = issue_valid_i & (waw | raw);
  assign issue_accept  = issue_valid_i & ~issue_stall_o;

  // Clear for the committing write is applied first so a same-cycle set wins.
  always_comb begin
    pend_d = pend;
    if (fregwrite_o) begin
      pend_d[frd_o] = 1'b0;
    end
    if (issue_accept & issue_wr_i) begin
      pend_d[issue_frd_i] = 1'b1;
    end
  end

  assign fpu_ready_o  = ~fifo_full;
  assign fifo_push    = fpu_valid_i & fpu_ready_o;
  assign fifo_pop     = ~ld_valid_i & ~fifo_empty;
  assign fifo_in.frd  = fpu_frd_i;
  assign fifo_in.data = fpu_data_i;

  fp_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (fifo_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend             <= '0;
      fregwrite_o      <= 1'b0;
      frd_o            <= '0;
      writeback_data_o <= '0;
    end else begin
      pend        <= pend_d;
      fregwrite_o <= ld_valid_i | ~fifo_empty;
      if (ld_valid_i) begin
        frd_o            <= ld_frd_i;
        writeback_data_o <= ld_data_i;
      end else if (!fifo_empty) begin
        frd_o            <= fifo_head.frd;
        writeback_data_o <= fifo_head.data;
      end
    end
  end

  assign idle_o = (pend == '0) & fifo_empty & ~fregwrite_o;

endmodule

// File: tb/tb_fp_writeback_ctrl.sv
// Directed bench for fp_writeback_ctrl with a write-order scoreboard.
module tb_fp_writeback_ctrl;
  import fp_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            issue_valid_i;
  logic [4:0]      issue_frd_i;
  logic            issue_wr_i;
  logic [2:0][4:0] issue_rs_i;
  logic [2:0]      issue_rs_use_i;
  logic            issue_stall_o;
  logic            fpu_valid_i;
  logic            fpu_ready_o;
  logic [4:0]      fpu_frd_i;
  logic [31:0]     fpu_data_i;
  logic            ld_valid_i;
  logic [4:0]      ld_frd_i;
  logic [31:0]     ld_data_i;
  logic            fregwrite_o;
  logic [4:0]      frd_o;
  logic [31:0]     writeback_data_o;
  logic            idle_o;

  int checks   = 0;
  int errors   = 0;
  int n_writes = 0;

  fp_wb_t mfifo[$];
  fp_wb_t exp_q[$];

  always #5 clk = ~clk;

  fp_writeback_ctrl #(
    .FLEN       (32),
    .NREG       (32),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .issue_valid_i    (issue_valid_i),
    .issue_frd_i      (issue_frd_i),
    .issue_wr_i       (issue_wr_i),
    .issue_rs_i       (issue_rs_i),
    .issue_rs_use_i   (issue_rs_use_i),
    .issue_stall_o    (issue_stall_o),
    .fpu_valid_i      (fpu_valid_i),
    .fpu_ready_o      (fpu_ready_o),
    .fpu_frd_i        (fpu_frd_i),
    .fpu_data_i       (fpu_data_i),
    .ld_valid_i       (ld_valid_i),
    .ld_frd_i         (ld_frd_i),
    .ld_data_i        (ld_data_i),
    .fregwrite_o      (fregwrite_o),
    .frd_o            (frd_o),
    .writeback_data_o (writeback_data_o),
    .idle_o           (idle_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: load wins, else buffered FPU result; buffer accepts only
  // when its occupancy before the edge is below DEPTH.
  task automatic model_step();
    fp_wb_t e;
    bit     can_push;
    if (!rst_ni) begin
      mfifo.delete();
      exp_q.delete();
    end else begin
      can_push = (mfifo.size() < DEPTH);
      if (ld_valid_i) begin
        e.frd  = ld_frd_i;
        e.data = ld_data_i;
        exp_q.push_back(e);
      end else if (mfifo.size() != 0) begin
        exp_q.push_back(mfifo.pop_front());
      end
      if (fpu_valid_i && can_push) begin
        e.frd  = fpu_frd_i;
        e.data = fpu_data_i;
        mfifo.push_back(e);
      end
    end
  endtask

  task automatic monitor_step();
    fp_wb_t e;
    check("wr_en", fregwrite_o, exp_q.size() != 0);
    if (fregwrite_o) n_writes++;
    if (fregwrite_o && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("wr_frd", frd_o, e.frd);
      check("wr_data", writeback_data_o, e.data);
    end
  endtask

  always @(posedge clk) model_step();
  always @(negedge clk) monitor_step();

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0; issue_valid_i = 1'b0; issue_frd_i = '0; issue_wr_i = 1'b0;
    issue_rs_i = '0; issue_rs_use_i = '0;
    fpu_valid_i = 1'b0; fpu_frd_i = '0; fpu_data_i = '0;
    ld_valid_i = 1'b0; ld_frd_i = '0; ld_data_i = '0;
    repeat (2) nxt();

    // Traffic, then a one-edge reset in the middle of it
    rst_ni = 1'b1;
    issue_valid_i = 1'b1; issue_wr_i = 1'b1; issue_frd_i = 5'd5;
    fpu_valid_i = 1'b1; fpu_frd_i = 5'd1; fpu_data_i = 32'h1111_1111;
    ld_valid_i = 1'b1; ld_frd_i = 5'd4; ld_data_i = 32'h4444_4444;
    nxt();
    issue_valid_i = 1'b0; fpu_valid_i = 1'b0; ld_valid_i = 1'b0; rst_ni = 1'b0;
    nxt();
    check("rst_we", fregwrite_o, 0);
    check("rst_frd", frd_o, 0);
    check("rst_data", writeback_data_o, 0);
    check("rst_idle", idle_o, 1);
    issue_valid_i = 1'b1; issue_wr_i = 1'b1; issue_frd_i = 5'd5;
    issue_rs_i[0] = 5'd5; issue_rs_use_i = 3'b111;
    #1 check("rst_stall", issue_stall_o, 0);
    issue_valid_i = 1'b0; rst_ni = 1'b1;
    nxt();

    // RAW stall on f5 until the FPU writes it back
    issue_valid_i = 1'b1; issue_wr_i = 1'b1; issue_frd_i = 5'd5; issue_rs_use_i = '0;
    #1 check("raw_first", issue_stall_o, 0);
    nxt();
    issue_wr_i = 1'b0; issue_rs_i[0] = 5'd5; issue_rs_use_i = 3'b001;
    #1 check("raw_stall0", issue_stall_o, 1);
    nxt();
    check("raw_stall1", issue_stall_o, 1);
    fpu_valid_i = 1'b1; fpu_frd_i = 5'd5; fpu_data_i = 32'h3F80_0000;
    #1 check("raw_ready", fpu_ready_o, 1);
    nxt();
    fpu_valid_i = 1'b0;
    #1 check("raw_nowr", fregwrite_o, 0);
    check("raw_stall2", issue_stall_o, 1);
    nxt();
    check("raw_we", fregwrite_o, 1);
    check("raw_frd", frd_o, 5);
    check("raw_data", writeback_data_o, 32'h3F80_0000);
    check("raw_stall3", issue_stall_o, 1);
    nxt();
    check("raw_release", issue_stall_o, 0);
    issue_valid_i = 1'b0;

    // Hazard matrix against pending f7
    issue_rs_i = '0; issue_rs_use_i = '0;
    issue_valid_i = 1'b1; issue_wr_i = 1'b1; issue_frd_i = 5'd7;
    #1 check("hz_accept", issue_stall_o, 0);
    nxt();
    check("hz_waw", issue_stall_o, 1);
    issue_wr_i = 1'b0; issue_rs_i[2] = 5'd7; issue_rs_use_i = 3'b011;
    #1 check("hz_rs3_unused", issue_stall_o, 0);
    issue_rs_use_i = 3'b100;
    #1 check("hz_rs3_used", issue_stall_o, 1);
    issue_valid_i = 1'b0;
    #1 check("hz_novalid", issue_stall_o, 0);
    check("hz_busy", idle_o, 0);
    issue_rs_i = '0; issue_rs_use_i = '0;
    ld_valid_i = 1'b1; ld_frd_i = 5'd7; ld_data_i = 32'h7777_7777;
    nxt();
    ld_valid_i = 1'b0;
    nxt();

    // Same-cycle clear and set of f9: set wins
    ld_valid_i = 1'b1; ld_frd_i = 5'd9; ld_data_i = 32'h9999_9999;
    nxt();
    ld_valid_i = 1'b0;
    issue_valid_i = 1'b1; issue_wr_i = 1'b1; issue_frd_i = 5'd9;
    #1 check("sc_accept", issue_stall_o, 0);
    nxt();
    issue_wr_i = 1'b0; issue_rs_i[0] = 5'd9; issue_rs_use_i = 3'b001;
    #1 check("sc_set_wins", issue_stall_o, 1);
    issue_valid_i = 1'b0;
    ld_valid_i = 1'b1; ld_frd_i = 5'd9; ld_data_i = 32'h9090_9090;
    nxt();
    ld_valid_i = 1'b0;
    nxt();
    issue_valid_i = 1'b1;
    #1 check("sc_cleared", issue_stall_o, 0);
    issue_valid_i = 1'b0; issue_rs_i = '0; issue_rs_use_i = '0;

    // Load beats FPU in the same cycle
    ld_valid_i = 1'b1; ld_frd_i = 5'd2; ld_data_i = 32'h4000_0000;
    fpu_valid_i = 1'b1; fpu_frd_i = 5'd3; fpu_data_i = 32'h4040_0000;
    #1 check("pr_ready", fpu_ready_o, 1);
    nxt();
    ld_valid_i = 1'b0; fpu_valid_i = 1'b0;
    check("pr_frd0", frd_o, 2);
    check("pr_data0", writeback_data_o, 32'h4000_0000);
    nxt();
    check("pr_frd1", frd_o, 3);
    check("pr_data1", writeback_data_o, 32'h4040_0000);
    nxt();
    check("pr_idle", idle_o, 1);

    // Backpressure: four loads while the FPU offers three results
    ld_valid_i = 1'b1; ld_frd_i = 5'd10; ld_data_i = 32'hA000_0000;
    fpu_valid_i = 1'b1; fpu_frd_i = 5'd20; fpu_data_i = 32'hB000_0000;
    #1 check("bp_ready0", fpu_ready_o, 1);
    nxt();
    ld_frd_i = 5'd11; ld_data_i = 32'hA000_0001;
    fpu_frd_i = 5'd21; fpu_data_i = 32'hB000_0001;
    #1 check("bp_ready1", fpu_ready_o, 1);
    nxt();
    ld_frd_i = 5'd12; ld_data_i = 32'hA000_0002;
    fpu_frd_i = 5'd22; fpu_data_i = 32'hB000_0002;
    #1 check("bp_ready2", fpu_ready_o, 0);
    nxt();
    ld_frd_i = 5'd13; ld_data_i = 32'hA000_0003;
    #1 check("bp_ready3", fpu_ready_o, 0);
    nxt();
    ld_valid_i = 1'b0;
    #1 check("bp_ready4", fpu_ready_o, 0);
    nxt();
    check("bp_ready5", fpu_ready_o, 1);
    nxt();
    fpu_valid_i = 1'b0;
    repeat (4) nxt();
    check("bp_idle", idle_o, 1);

    check("sb_drained", exp_q.size(), 0);
    check("write_count", n_writes, 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_writeback_ctrl.md
Name: fp_writeback_ctrl

Overview:
- Write-side controller for the FP register file: owns the file's single write port (fregwrite, frd, writeback data).
- Merges results from the multi-cycle FPU and the FP load path.
- Keeps a 32-entry pending-write scoreboard and stalls issue on RAW/WAW hazards against in-flight destinations.
- Sits between the FP issue stage / execution units and the register file.

Parameters:
- FLEN, 32, FP data width.
- NREG, 32, number of FP registers; register index width is $clog2(NREG).
- FIFO_DEPTH, 2, FPU result buffer entries (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- issue_valid_i  in  1  FP instruction presented at issue
- issue_frd_i  in  5  destination register
- issue_wr_i  in  1  instruction writes an FP register
- issue_rs_i  in  3x5  freg1/freg2/freg3 source indices
- issue_rs_use_i  in  3  per-source used flags
- issue_stall_o  out  1  hazard: hold issue this cycle
- fpu_valid_i  in  1  FPU result valid
- fpu_ready_o  out  1  FPU result accepted
- fpu_frd_i  in  5  FPU result destination
- fpu_data_i  in  FLEN  FPU result
- ld_valid_i  in  1  load result valid (no backpressure)
- ld_frd_i  in  5  load destination
- ld_data_i  in  FLEN  load data
- fregwrite_o  out  1  register file write enable
- frd_o  out  5  register file write index
- writeback_data_o  out  FLEN  register file write data
- idle_o  out  1  scoreboard empty and FIFO empty

Behaviour:
- Reset is synchronous, active-low. rst_ni low at a clock edge clears:
  - scoreboard to all-zero, FIFO pointers and count to 0;
  - fregwrite_o=0, frd_o=0, writeback_data_o=0.
- Reset mid-operation discards buffered results and pending bits; idle_o=1 the cycle after.
- Hazard logic (combinational):
  - issue_stall_o = issue_valid_i & (WAW | RAW).
  - WAW = issue_wr_i & pend[issue_frd_i].
  - RAW = OR over k of (issue_rs_use_i[k] & pend[issue_rs_i[k]]).
  - Issue is accepted when issue_valid_i & !issue_stall_o.
- Scoreboard updates:
  - An accepted issue with issue_wr_i sets pend[issue_frd_i] at the next edge.
  - A committed write (fregwrite_o=1) clears pend[frd_o] at that edge.
  - Set and clear of the same index in the same cycle: set wins.
- FPU path:
  - fpu_ready_o = !fifo_full.
  - A result enqueues when fpu_valid_i & fpu_ready_o.
  - An enqueue into a full FIFO never occurs. A simultaneous dequeue does not raise ready in the same cycle; ready is computed from registered count only.
- Arbitration, one write per cycle:
  - ld_valid_i has absolute priority.
  - Otherwise the FIFO head is selected if non-empty.
  - The selected source is registered onto fregwrite_o/frd_o/writeback_data_o: 1-cycle latency from ld_valid_i, 1 cycle from FIFO head.
  - FIFO dequeue occurs only when the head is selected.
  - With no source, fregwrite_o=0 and frd_o/data hold their last value.
- Latency: FPU result on an empty FIFO with no load is enqueued at edge N, written out at edge N+1.
- Register index 0 is an ordinary register (F extension); no special casing.
- A result whose destination is not pending is still written; the scoreboard is unchanged.
- idle_o = (pend==0) & fifo_empty & !fregwrite_o.

Decomposition:
- Shared package fp_pkg:
  - FLEN, NREG, REG_AW constants;
  - typedef freg_idx_t (logic [REG_AW-1:0]);
  - struct fp_wb_t {freg_idx_t frd; logic [FLEN-1:0] data}.
- Sub-module fp_wb_fifo: parameterised depth, fp_wb_t payload, push/pop/full/empty, synchronous active-low reset.

Test Plan:
- Reset: drive traffic, assert rst_ni low one edge -> fregwrite_o=0, frd_o=0, data=0, issue_stall_o=0 for any issue, idle_o=1.
- RAW stall: issue frd=5 wr=1, then issue rs1=5 used -> stall=1 until FPU writes f5=0x3F800000; fregwrite_o=1 frd_o=5 one cycle after fpu_valid_i; stall drops the following cycle.
- WAW/RAW hazard matrix: pend f7 -> issue frd=7 stalls; issue rs3=7 with use[2]=0 does not stall; use[2]=1 stalls.
- Load priority: ld_valid_i (f2, 0x40000000) and fpu_valid_i (f3, 0x40400000) in the same cycle -> f2 written at N+1, f3 at N+2, FIFO count returns to 0.
- Backpressure: hold ld_valid_i for 4 cycles while FPU pushes 3 results -> fpu_ready_o=0 after 2 accepted; all 3 written in order after loads stop; no loss or duplication.
- Same-index set/clear: writeback of f9 commits in the same cycle an issue with frd=9 is accepted -> pend[9]=1 afterwards.
